// File: rtl/rf_ft_pkg.sv
// Shared types and constants for the register-file fault-tolerance blocks.
// Holds the scrub FSM state type and the scrub pointer wrap helper.
package rf_ft_pkg;

  localparam int         RF_NREGS       = 32;
  localparam logic [4:0] RF_FIRST_SCRUB = 5'd1;
  localparam int         SEC_CNT_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WB,
    S_REMAP
  } rf_scrub_state_e;

  // x0 is hard-wired, so the walk skips it on wrap.
  function automatic logic [4:0] rf_next_ptr(input logic [4:0] p);
    return (p == 5'd31) ? RF_FIRST_SCRUB : p + 5'd1;
  endfunction

endpackage

// File: rtl/rf_fault_cnt_bank.sv
// Per-location correction counters with a threshold-hit flag for the selected
// location; counters of locations already remapped are held at zero.
module rf_fault_cnt_bank
  import rf_ft_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_inc,
  input  logic                i_clr,
  input  logic [4:0]          i_addr,
  input  logic [RF_NREGS-1:0] i_damaged,
  output logic                o_hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(THRESH - 1);

  logic [CNT_W-1:0] r_cnt [RF_NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_NREGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < RF_NREGS; i++) begin
        if (i_damaged[i]) begin
          r_cnt[i] <= '0;
        end else if (i_clr && (i_addr == 5'(i))) begin
          r_cnt[i] <= '0;
        end else if (i_inc && (i_addr == 5'(i)) && (r_cnt[i] != CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Hit means this increment is the one that reaches THRESH.
  assign o_hit = i_inc & ~i_damaged[i_addr] & (r_cnt[i_addr] == HIT_VAL);

endmodule

// File: rtl/rf_scrub_ctrl.sv
// Background scrubber: steals idle read port C / write port B cycles to walk
// x1..x31, write back corrected words and remap locations that keep failing.
module rf_scrub_ctrl
  import rf_ft_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scrub_en_i,
  input  logic [15:0]          interval_i,
  input  logic                 port_c_busy_i,
  input  logic                 port_b_busy_i,
  input  logic                 core_we_a_i,
  input  logic [4:0]           core_waddr_a_i,
  input  logic                 core_we_b_i,
  input  logic [4:0]           core_waddr_b_i,
  output logic                 scrub_re_o,
  output logic [4:0]           scrub_raddr_o,
  input  logic [31:0]          rdata_c_i,
  input  logic                 sec_c_i,
  input  logic                 ded_c_i,
  output logic                 scrub_we_o,
  output logic [4:0]           scrub_waddr_o,
  output logic [31:0]          scrub_wdata_o,
  input  logic                 load_damaged_i,
  input  logic [31:0]          damaged_init_i,
  output logic [31:0]          damaged_o,
  output logic                 damaged_upd_o,
  output logic [SEC_CNT_W-1:0] sec_count_o,
  output logic                 ded_flag_o,
  output logic [4:0]           ded_addr_o,
  input  logic                 ded_clr_i
);

  rf_scrub_state_e      r_state, w_next;
  logic [4:0]           r_ptr;
  logic [15:0]          r_timer;
  logic [4:0]           r_addr;
  logic [31:0]          r_data;
  logic                 r_stale;
  logic [RF_NREGS-1:0]  r_damaged;
  logic                 r_upd;
  logic [SEC_CNT_W-1:0] r_sec_cnt;
  logic                 r_ded_flag;
  logic [4:0]           r_ded_addr;

  logic                 w_sample, w_sec_ev, w_ded_ev;
  logic                 w_hit_ptr, w_hit_addr, w_cancel, w_wb_done;
  logic                 w_cnt_hit, w_load_timer, w_adv_ptr;
  logic [4:0]           w_bank_addr;
  logic [RF_NREGS-1:0]  w_remap_set;

  // A read is only issued while enabled, so a disable never drops a sampled error.
  assign w_sample   = (r_state == S_READ) & scrub_en_i & ~port_c_busy_i;
  assign w_ded_ev   = w_sample & ded_c_i;
  assign w_sec_ev   = w_sample & sec_c_i & ~ded_c_i;

  assign w_hit_ptr  = (core_we_a_i & (core_waddr_a_i == r_ptr)) |
                      (core_we_b_i & (core_waddr_b_i == r_ptr));
  assign w_hit_addr = (core_we_a_i & (core_waddr_a_i == r_addr)) |
                      (core_we_b_i & (core_waddr_b_i == r_addr));
  assign w_cancel   = (r_state == S_WB) & (r_stale | w_hit_addr);
  assign w_wb_done  = (r_state == S_WB) & (w_cancel | ~port_b_busy_i);

  assign w_bank_addr = (r_state == S_REMAP) ? r_addr : r_ptr;
  assign w_remap_set = (r_state == S_REMAP) ? (RF_NREGS'(1) << r_addr) : '0;

  rf_fault_cnt_bank #(.THRESH(THRESH), .CNT_W(CNT_W)) u_cnt_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_sec_ev),
    .i_clr     (r_state == S_REMAP),
    .i_addr    (w_bank_addr),
    .i_damaged (r_damaged),
    .o_hit     (w_cnt_hit)
  );

  always_comb begin
    w_next       = r_state;
    w_load_timer = 1'b0;
    w_adv_ptr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (scrub_en_i) begin
          w_next       = S_WAIT;
          w_load_timer = 1'b1;
        end
      end
      S_WAIT: begin
        if (!scrub_en_i)          w_next = S_IDLE;
        else if (r_timer == '0)   w_next = S_READ;
      end
      S_READ: begin
        if (!scrub_en_i) begin
          w_next = S_IDLE;
        end else if (w_sec_ev) begin
          w_next = w_cnt_hit ? S_REMAP : S_WB;
        end else if (w_sample) begin
          w_next       = S_WAIT;
          w_adv_ptr    = 1'b1;
          w_load_timer = 1'b1;
        end
      end
      S_REMAP: w_next = S_WB;
      S_WB: begin
        if (w_wb_done) begin
          w_adv_ptr    = 1'b1;
          w_load_timer = scrub_en_i;
          w_next       = scrub_en_i ? S_WAIT : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= RF_FIRST_SCRUB;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_adv_ptr) r_ptr <= rf_next_ptr(r_ptr);
      if (w_load_timer)                              r_timer <= interval_i;
      else if ((r_state == S_WAIT) && (r_timer != '0)) r_timer <= r_timer - 16'd1;
    end
  end

  // Any core write to the latched location after it was read makes the write-back stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= RF_FIRST_SCRUB;
      r_data  <= '0;
      r_stale <= 1'b0;
    end else if (w_sec_ev) begin
      r_addr  <= r_ptr;
      r_data  <= rdata_c_i;
      r_stale <= w_hit_ptr;
    end else if (w_wb_done) begin
      r_stale <= 1'b0;
    end else if (((r_state == S_REMAP) || (r_state == S_WB)) && w_hit_addr) begin
      r_stale <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_damaged  <= '0;
      r_upd      <= 1'b0;
      r_sec_cnt  <= '0;
      r_ded_flag <= 1'b0;
      r_ded_addr <= '0;
    end else begin
      r_damaged <= (load_damaged_i ? damaged_init_i : r_damaged) | w_remap_set;
      r_upd     <= (r_state == S_REMAP);
      if (w_sec_ev && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + SEC_CNT_W'(1);
      // A new uncorrectable read beats a simultaneous clear.
      if (w_ded_ev && (!r_ded_flag || ded_clr_i)) begin
        r_ded_flag <= 1'b1;
        r_ded_addr <= r_ptr;
      end else if (ded_clr_i) begin
        r_ded_flag <= 1'b0;
        r_ded_addr <= '0;
      end
    end
  end

  assign scrub_re_o    = w_sample;
  assign scrub_raddr_o = r_ptr;
  assign scrub_we_o    = (r_state == S_WB) & ~port_b_busy_i & ~w_cancel;
  assign scrub_waddr_o = r_addr;
  assign scrub_wdata_o = r_data;
  assign damaged_o     = r_damaged;
  assign damaged_upd_o = r_upd;
  assign sec_count_o   = r_sec_cnt;
  assign ded_flag_o    = r_ded_flag;
  assign ded_addr_o    = r_ded_addr;

endmodule

// File: tb/tb_rf_scrub_ctrl.sv
// Directed bench for rf_scrub_ctrl: a behavioural decoder answers port C reads
// from an injection mask, and each step compares outputs to hand-derived values.
module tb_rf_scrub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scrub_en_i;
  logic [15:0] interval_i;
  logic        port_c_busy_i, port_b_busy_i;
  logic        core_we_a_i, core_we_b_i;
  logic [4:0]  core_waddr_a_i, core_waddr_b_i;
  logic        scrub_re_o, scrub_we_o;
  logic [4:0]  scrub_raddr_o, scrub_waddr_o;
  logic [31:0] rdata_c_i, scrub_wdata_o;
  logic        sec_c_i, ded_c_i;
  logic        load_damaged_i;
  logic [31:0] damaged_init_i, damaged_o;
  logic        damaged_upd_o;
  logic [15:0] sec_count_o;
  logic        ded_flag_o;
  logic [4:0]  ded_addr_o;
  logic        ded_clr_i;

  logic [31:0] secMask, dedMask;
  int          checks = 0;
  int          errors = 0;
  int          weCount = 0;
  int          weBase;
  int          gap;

  rf_scrub_ctrl #(.THRESH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en_i(scrub_en_i), .interval_i(interval_i),
    .port_c_busy_i(port_c_busy_i), .port_b_busy_i(port_b_busy_i),
    .core_we_a_i(core_we_a_i), .core_waddr_a_i(core_waddr_a_i),
    .core_we_b_i(core_we_b_i), .core_waddr_b_i(core_waddr_b_i),
    .scrub_re_o(scrub_re_o), .scrub_raddr_o(scrub_raddr_o), .rdata_c_i(rdata_c_i),
    .sec_c_i(sec_c_i), .ded_c_i(ded_c_i), .scrub_we_o(scrub_we_o),
    .scrub_waddr_o(scrub_waddr_o), .scrub_wdata_o(scrub_wdata_o),
    .load_damaged_i(load_damaged_i), .damaged_init_i(damaged_init_i),
    .damaged_o(damaged_o), .damaged_upd_o(damaged_upd_o), .sec_count_o(sec_count_o),
    .ded_flag_o(ded_flag_o), .ded_addr_o(ded_addr_o), .ded_clr_i(ded_clr_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input logic [4:0] a);
    return 32'hC0DE_0000 | {19'd0, a, 3'b101, a};
  endfunction

  // Corrected decoder output for whatever location the scrubber addresses.
  always_comb begin
    rdata_c_i = golden(scrub_raddr_o);
    sec_c_i   = secMask[scrub_raddr_o];
    ded_c_i   = dedMask[scrub_raddr_o];
  end

  always @(posedge clk) if (scrub_we_o) weCount <= weCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitRead(output int cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      applyStimulus(1);
      cycles++;
      if (scrub_re_o) found = 1'b1;
    end
    checkOutput("read_found", {31'd0, found}, 32'd1);
  endtask

  task automatic waitReadAddr(input logic [4:0] a);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      applyStimulus(1);
      if (scrub_re_o && scrub_raddr_o == a) found = 1'b1;
    end
    checkOutput("read_addr_found", {31'd0, found}, 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_re"},      {31'd0, scrub_re_o}, 32'd0);
    checkOutput({tag, "_we"},      {31'd0, scrub_we_o}, 32'd0);
    checkOutput({tag, "_raddr"},   {27'd0, scrub_raddr_o}, 32'd1);
    checkOutput({tag, "_waddr"},   {27'd0, scrub_waddr_o}, 32'd1);
    checkOutput({tag, "_wdata"},   scrub_wdata_o, 32'd0);
    checkOutput({tag, "_damaged"}, damaged_o, 32'd0);
    checkOutput({tag, "_upd"},     {31'd0, damaged_upd_o}, 32'd0);
    checkOutput({tag, "_seccnt"},  {16'd0, sec_count_o}, 32'd0);
    checkOutput({tag, "_dedflag"}, {31'd0, ded_flag_o}, 32'd0);
    checkOutput({tag, "_dedaddr"}, {27'd0, ded_addr_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] expAddr;
    rst_n = 1'b0; scrub_en_i = 1'b0; interval_i = 16'd0;
    port_c_busy_i = 1'b0; port_b_busy_i = 1'b0;
    core_we_a_i = 1'b0; core_waddr_a_i = 5'd0; core_we_b_i = 1'b0; core_waddr_b_i = 5'd0;
    load_damaged_i = 1'b0; damaged_init_i = 32'd0; ded_clr_i = 1'b0;
    secMask = 32'd0; dedMask = 32'd0;
    applyStimulus(3);
    checkResetState("reset");

    // Clean walk with interval 0: reads every 2 cycles, 1..31 then wrap to 1.
    rst_n = 1'b1; scrub_en_i = 1'b1;
    expAddr = 5'd1;
    for (int k = 0; k < 32; k++) begin
      waitRead(gap);
      checkOutput("walk_raddr", {27'd0, scrub_raddr_o}, {27'd0, expAddr});
      checkOutput("walk_gap", gap, 32'd2);
      expAddr = (expAddr == 5'd31) ? 5'd1 : expAddr + 5'd1;
    end
    interval_i = 16'd3;
    waitRead(gap);
    checkOutput("interval_raddr", {27'd0, scrub_raddr_o}, 32'd2);
    checkOutput("interval_gap", gap, 32'd5);
    interval_i = 16'd0;
    scrub_en_i = 1'b0;
    applyStimulus(4);
    checkOutput("disabled_re", {31'd0, scrub_re_o}, 32'd0);
    checkOutput("walk_no_we", weCount, 32'd0);
    checkOutput("walk_seccnt", {16'd0, sec_count_o}, 32'd0);

    // Single SEC at x5: one corrected write-back, no remap.
    secMask[5] = 1'b1; scrub_en_i = 1'b1;
    waitReadAddr(5'd5);
    checkOutput("sec5_pre_cnt", {16'd0, sec_count_o}, 32'd0);
    applyStimulus(1);
    secMask[5] = 1'b0;
    checkOutput("sec5_we", {31'd0, scrub_we_o}, 32'd1);
    checkOutput("sec5_waddr", {27'd0, scrub_waddr_o}, 32'd5);
    checkOutput("sec5_wdata", scrub_wdata_o, golden(5'd5));
    checkOutput("sec5_cnt", {16'd0, sec_count_o}, 32'd1);
    checkOutput("sec5_damaged", damaged_o, 32'd0);
    waitRead(gap);
    checkOutput("sec5_next_raddr", {27'd0, scrub_raddr_o}, 32'd6);
    checkOutput("sec5_next_gap", gap, 32'd2);

    // Repeated SEC at x7: the fourth correction remaps it.
    secMask[7] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      waitReadAddr(5'd7);
      applyStimulus(1);
      checkOutput("sec7_we", {31'd0, scrub_we_o}, 32'd1);
      checkOutput("sec7_waddr", {27'd0, scrub_waddr_o}, 32'd7);
      checkOutput("sec7_damaged", damaged_o, 32'd0);
    end
    waitReadAddr(5'd7);
    applyStimulus(1);
    checkOutput("remap_state_we", {31'd0, scrub_we_o}, 32'd0);
    checkOutput("remap_state_upd", {31'd0, damaged_upd_o}, 32'd0);
    applyStimulus(1);
    checkOutput("remap_damaged", damaged_o, 32'h0000_0080);
    checkOutput("remap_upd", {31'd0, damaged_upd_o}, 32'd1);
    checkOutput("remap_wb_we", {31'd0, scrub_we_o}, 32'd1);
    checkOutput("remap_wb_waddr", {27'd0, scrub_waddr_o}, 32'd7);
    applyStimulus(1);
    checkOutput("remap_upd_pulse_end", {31'd0, damaged_upd_o}, 32'd0);
    waitReadAddr(5'd7);
    applyStimulus(1);
    secMask[7] = 1'b0;
    checkOutput("damaged7_sec_we", {31'd0, scrub_we_o}, 32'd1);
    checkOutput("damaged7_no_upd", {31'd0, damaged_upd_o}, 32'd0);
    checkOutput("sec7_total_cnt", {16'd0, sec_count_o}, 32'd6);

    // DED handling: first address sticks, clear works, new DED beats clear.
    dedMask[9] = 1'b1; dedMask[12] = 1'b1;
    waitReadAddr(5'd9);
    applyStimulus(1);
    dedMask[9] = 1'b0;
    checkOutput("ded9_flag", {31'd0, ded_flag_o}, 32'd1);
    checkOutput("ded9_addr", {27'd0, ded_addr_o}, 32'd9);
    checkOutput("ded9_no_we", {31'd0, scrub_we_o}, 32'd0);
    waitReadAddr(5'd12);
    applyStimulus(1);
    dedMask[12] = 1'b0;
    checkOutput("ded12_keeps_addr", {27'd0, ded_addr_o}, 32'd9);
    ded_clr_i = 1'b1;
    applyStimulus(1);
    ded_clr_i = 1'b0;
    checkOutput("dedclr_flag", {31'd0, ded_flag_o}, 32'd0);
    checkOutput("dedclr_addr", {27'd0, ded_addr_o}, 32'd0);
    dedMask[14] = 1'b1;
    waitReadAddr(5'd14);
    applyStimulus(1);
    dedMask[14] = 1'b0;
    checkOutput("ded14_addr", {27'd0, ded_addr_o}, 32'd14);
    dedMask[16] = 1'b1;
    waitReadAddr(5'd16);
    ded_clr_i = 1'b1;
    applyStimulus(1);
    ded_clr_i = 1'b0; dedMask[16] = 1'b0;
    checkOutput("ded_vs_clr_flag", {31'd0, ded_flag_o}, 32'd1);
    checkOutput("ded_vs_clr_addr", {27'd0, ded_addr_o}, 32'd16);

    // SEC at x3 with port B busy for 10 cycles: write-back is held off.
    secMask[3] = 1'b1;
    waitReadAddr(5'd3);
    port_b_busy_i = 1'b1;
    applyStimulus(1);
    secMask[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("busy_b_no_we", {31'd0, scrub_we_o}, 32'd0);
      if (i < 9) applyStimulus(1);
    end
    port_b_busy_i = 1'b0;
    #1;
    checkOutput("busy_release_we", {31'd0, scrub_we_o}, 32'd1);
    checkOutput("busy_release_waddr", {27'd0, scrub_waddr_o}, 32'd3);
    checkOutput("busy_release_wdata", scrub_wdata_o, golden(5'd3));
    applyStimulus(1);
    checkOutput("busy_release_done", {31'd0, scrub_we_o}, 32'd0);

    // Same, but a core write to x3 while waiting cancels the write-back.
    secMask[3] = 1'b1;
    waitReadAddr(5'd3);
    port_b_busy_i = 1'b1;
    applyStimulus(1);
    secMask[3] = 1'b0;
    weBase = weCount;
    checkOutput("cancel_wait_we", {31'd0, scrub_we_o}, 32'd0);
    applyStimulus(1);
    core_we_a_i = 1'b1; core_waddr_a_i = 5'd3;
    #1;
    checkOutput("cancel_same_cycle_we", {31'd0, scrub_we_o}, 32'd0);
    applyStimulus(1);
    core_we_a_i = 1'b0; core_waddr_a_i = 5'd0; port_b_busy_i = 1'b0;
    #1;
    checkOutput("cancel_after_we", {31'd0, scrub_we_o}, 32'd0);
    waitRead(gap);
    checkOutput("cancel_next_raddr", {27'd0, scrub_raddr_o}, 32'd4);
    checkOutput("cancel_no_writes", weCount - weBase, 32'd0);
    checkOutput("total_seccnt", {16'd0, sec_count_o}, 32'd8);

    // Reset while a write-back is pending in WB.
    secMask[20] = 1'b1;
    waitReadAddr(5'd20);
    port_b_busy_i = 1'b1;
    applyStimulus(1);
    checkOutput("wb_pending_we", {31'd0, scrub_we_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkResetState("midreset");
    secMask = 32'd0; port_b_busy_i = 1'b0; scrub_en_i = 1'b0;
    applyStimulus(2);
    rst_n = 1'b1;

    // Loading a saved damaged map does not pulse the update strobe.
    damaged_init_i = 32'h0000_0F00; load_damaged_i = 1'b1;
    applyStimulus(1);
    load_damaged_i = 1'b0;
    checkOutput("load_damaged", damaged_o, 32'h0000_0F00);
    checkOutput("load_no_upd", {31'd0, damaged_upd_o}, 32'd0);
    applyStimulus(1);
    checkOutput("load_no_upd_later", {31'd0, damaged_upd_o}, 32'd0);
    checkOutput("load_damaged_held", damaged_o, 32'h0000_0F00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
